// File: rtl/activation_unit_if.sv
// activation_unit_if: beat stream in and out, per-beat config, stats.
// master drives beats/config, slave is the activation pipeline.
interface activation_unit_if #(
  parameter int IN_W    = 24,
  parameter int OUT_W   = 8,
  parameter int LANES   = 4,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic [1:0]             cfg_mode;
  logic [SHIFT_W-1:0]     cfg_shift;
  logic [OUT_W-1:0]       cfg_clip;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   clr_stats;
  logic [CNT_W-1:0]       sat_count;

  modport master (
    output in_valid,
    output in_data,
    output cfg_mode,
    output cfg_shift,
    output cfg_clip,
    output out_ready,
    output clr_stats,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sat_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  cfg_mode,
    input  cfg_shift,
    input  cfg_clip,
    input  out_ready,
    input  clr_stats,
    output in_ready,
    output out_valid,
    output out_data,
    output sat_count
  );
endinterface

// File: rtl/activation_unit.sv
// activation_unit: two-stage multi-lane requantise + activation pipeline
// with per-beat config, valid/ready backpressure and saturation stats.
module activation_unit #(
  parameter int IN_W    = 24,
  parameter int OUT_W   = 8,
  parameter int LANES   = 4,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  activation_unit_if.slave bus
);
  localparam int RW   = IN_W + 1;
  localparam int OMAX = 2**(OUT_W-1) - 1;

  typedef logic signed [RW-1:0] r_t;

  typedef struct packed {
    r_t [LANES-1:0]   r;
    logic [1:0]       mode;
    logic [OUT_W-1:0] clip;
  } s1_t;

  s1_t                    s1_q;
  s1_t                    s1_d;
  logic                   s1_valid;
  logic                   s1_en;
  logic                   s2_en;
  logic                   out_valid_q;
  logic [LANES*OUT_W-1:0] out_q;
  logic [LANES*OUT_W-1:0] act_d;
  logic                   any_sat;
  logic [CNT_W-1:0]       cnt_q;
  logic [OUT_W:0]         res;
  r_t                     lane_r;

  // One extra bit of headroom so the rounding bias cannot wrap.
  function automatic r_t requant(
    input logic [IN_W-1:0]    x,
    input logic [SHIFT_W-1:0] sh
  );
    r_t ext;
    r_t bias;
    ext  = {x[IN_W-1], x};
    bias = '0;
    if (sh != '0)
      bias = r_t'(1) << (sh - SHIFT_W'(1));
    return (ext + bias) >>> sh;
  endfunction

  // Returns {saturated, clamped value}; the mode-3 clip is not saturation.
  function automatic logic [OUT_W:0] activate(
    input r_t               r,
    input logic [1:0]       mode,
    input logic [OUT_W-1:0] clip
  );
    r_t   a;
    r_t   c;
    r_t   hi;
    r_t   lo;
    logic neg;
    neg = r[RW-1];
    c   = r_t'({1'b0, clip});
    hi  = r_t'(OMAX);
    lo  = r_t'(-OMAX - 1);
    a   = r;
    unique case (1'b1)
      mode == 2'd0: a = r;
      mode == 2'd1: a = neg ? r_t'(0) : r;
      mode == 2'd2: a = neg ? (r >>> 3) : r;
      mode == 2'd3: a = neg ? r_t'(0) : ((r > c) ? c : r);
    endcase
    if (a > hi)
      return {1'b1, hi[OUT_W-1:0]};
    if (a < lo)
      return {1'b1, lo[OUT_W-1:0]};
    return {1'b0, a[OUT_W-1:0]};
  endfunction

  always_comb begin
    s1_d      = '0;
    s1_d.mode = bus.cfg_mode;
    s1_d.clip = bus.cfg_clip;
    for (int i = 0; i < LANES; i++)
      s1_d.r[i] = requant(bus.in_data[i*IN_W +: IN_W], bus.cfg_shift);
  end

  always_comb begin
    act_d   = '0;
    any_sat = 1'b0;
    res     = '0;
    lane_r  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_r = s1_q.r[i];
      res    = activate(lane_r, s1_q.mode, s1_q.clip);
      act_d[i*OUT_W +: OUT_W] = res[OUT_W-1:0];
      any_sat = any_sat | res[OUT_W];
    end
  end

  assign s2_en        = !out_valid_q | bus.out_ready;
  assign s1_en        = !s1_valid | s2_en;
  assign bus.in_ready = s1_en & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid)
          s1_q <= s1_d;
      end
      if (s2_en) begin
        out_valid_q <= s1_valid;
        if (s1_valid)
          out_q <= act_d;
      end
      if (bus.clr_stats)
        cnt_q <= '0;
      else if (s2_en && s1_valid && any_sat && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.sat_count = cnt_q;

endmodule

// File: tb/tb_activation_unit.sv
// tb_activation_unit: directed and randomised checks of activation_unit
// against an arithmetic reference model with an in-order scoreboard.
module tb_activation_unit;
  localparam int IN_W    = 24;
  localparam int OUT_W   = 8;
  localparam int LANES   = 4;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  activation_unit_if #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES),
    .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
  ) bus ();

  activation_unit #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES),
    .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int sat_model = 0;
  logic [LANES*OUT_W-1:0] expq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint v, input longint d);
    if (v >= 0)
      return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Reference: round-half-up division by 2^shift, then activation, then clamp.
  function automatic void model(
    input  logic [LANES*IN_W-1:0]  d,
    input  logic [1:0]             m,
    input  logic [SHIFT_W-1:0]     sh,
    input  logic [OUT_W-1:0]       cl,
    output logic [LANES*OUT_W-1:0] o,
    output bit                     s
  );
    logic [IN_W-1:0] raw;
    longint x, p, r, a, c, lim;
    s = 1'b0;
    o = '0;
    p = longint'(1) << sh;
    lim = longint'(cl);
    for (int i = 0; i < LANES; i++) begin
      raw = d[i*IN_W +: IN_W];
      x = longint'(signed'(raw));
      r = fdiv(x + p / 2, p);
      case (m)
        2'd0:    a = r;
        2'd1:    a = (r < 0) ? 0 : r;
        2'd2:    a = (r < 0) ? fdiv(r, 8) : r;
        default: a = (r < 0) ? 0 : ((r > lim) ? lim : r);
      endcase
      c = (a > 127) ? 127 : ((a < -128) ? -128 : a);
      if (c != a)
        s = 1'b1;
      o[i*OUT_W +: OUT_W] = OUT_W'(c);
    end
  endfunction

  function automatic logic [LANES*IN_W-1:0] pk(input int a0, input int a1,
                                               input int a2, input int a3);
    return {IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
  endfunction

  function automatic logic [LANES*IN_W-1:0] rnd_lanes();
    logic [LANES*IN_W-1:0] d;
    int v;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(0, 1) == 1)
        v = int'($urandom);
      else
        v = int'($urandom_range(0, 4000)) - 2000;
      d[i*IN_W +: IN_W] = IN_W'(v);
    end
    return d;
  endfunction

  // One clock: scoreboard push on accept, pop/compare on transfer,
  // in_ready against occupancy, stability while stalled.
  task automatic step();
    logic [LANES*OUT_W-1:0] o;
    logic [LANES*OUT_W-1:0] held;
    logic [LANES*OUT_W-1:0] e;
    bit s;
    bit stall;
    logic rdy_exp;
    #1;
    rdy_exp = !rst && (expq.size() < 2 || bus.out_ready);
    chk("in_ready", bus.in_ready, rdy_exp);
    if (bus.in_valid && bus.in_ready) begin
      model(bus.in_data, bus.cfg_mode, bus.cfg_shift, bus.cfg_clip, o, s);
      expq.push_back(o);
      if (s && sat_model < CMAX)
        sat_model++;
    end
    if (bus.out_valid && bus.out_ready && !rst) begin
      if (expq.size() == 0) begin
        chk("spurious_beat", bus.out_valid, 1'b0);
      end else begin
        e = expq.pop_front();
        chk("out_data", bus.out_data, e);
      end
    end
    stall = !rst && bus.out_valid && !bus.out_ready;
    held  = bus.out_data;
    @(posedge clk);
    @(negedge clk);
    if (stall) begin
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_data", bus.out_data, held);
    end
  endtask

  task automatic beat(input logic [1:0] m, input logic [SHIFT_W-1:0] sh,
                      input logic [OUT_W-1:0] cl,
                      input logic [LANES*IN_W-1:0] d);
    bit acc;
    acc = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.cfg_mode  = m;
    bus.cfg_shift = sh;
    bus.cfg_clip  = cl;
    for (int n = 0; n < 20 && !acc; n++) begin
      #1;
      acc = bus.in_ready;
      step();
    end
    if (!acc)
      chk("beat_accept_timeout", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag,
                            input logic [LANES*OUT_W-1:0] exp);
    for (int n = 0; n < 10 && !bus.out_valid; n++)
      step();
    chk(tag, bus.out_data, exp);
    step();
  endtask

  initial begin
    bit acc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_shift = '0;
    bus.cfg_clip  = '0;
    bus.out_ready = 1'b1;
    bus.clr_stats = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sat_count", bus.sat_count, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1'b1);

    beat(2'd1, 5'd0, 8'd0, pk(5, 200, 65535, -5));
    chk("lat_cycle1", bus.out_valid, 1'b0);
    step();
    chk("lat_cycle2", bus.out_valid, 1'b1);
    expect_out("relu_sat", 32'h007f7f05);
    chk("sat_after_relu", bus.sat_count, 1);

    beat(2'd0, 5'd0, 8'd0, pk(-8388608, 8388607, -128, 127));
    expect_out("ident_extremes", 32'h7f807f80);
    chk("sat_after_ident", bus.sat_count, 2);

    beat(2'd0, 5'd4, 8'd0, pk(24, 23, -24, -25));
    expect_out("round_shift4", 32'hfeff0102);
    beat(2'd0, 5'd0, 8'd0, pk(1, -1, 100, -100));
    expect_out("shift0_pass", 32'h9c64ff01);
    beat(2'd2, 5'd0, 8'd0, pk(-5, -16, -1, 40));
    expect_out("leaky", 32'h28fffeff);
    beat(2'd3, 5'd8, 8'd6, pk(1536, 2000, -300, 256));
    expect_out("clip_relu", 32'h01000606);
    step();
    chk("sat_after_clip", bus.sat_count, 2);
    chk("sat_model_directed", bus.sat_count, 32'(sat_model));

    for (int b = 0; b < 10; b++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = rnd_lanes();
      bus.cfg_mode  = 2'($urandom_range(0, 3));
      bus.cfg_shift = SHIFT_W'($urandom_range(0, IN_W - 1));
      bus.cfg_clip  = OUT_W'($urandom_range(0, 127));
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
        if (b < 2 || (b == 2 && n == 0))
          bus.out_ready = 1'b0;
        else
          bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        if (b == 2 && n == 0)
          chk("full_in_ready", bus.in_ready, 1'b0);
        acc = bus.in_ready;
        step();
      end
      if (!acc)
        chk("bp_accept_timeout", bus.in_ready, 1'b1);
    end
    bus.in_valid = 1'b0;
    for (int n = 0; n < 200 && expq.size() > 0; n++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("bp_drained", 64'(expq.size()), 0);
    bus.out_ready = 1'b1;
    step();
    chk("sat_model_bp", bus.sat_count, 32'(sat_model));

    bus.out_ready = 1'b0;
    beat(2'd0, 5'd0, 8'd0, pk(1, 2, 3, 4));
    beat(2'd0, 5'd0, 8'd0, pk(5, 6, 7, 8));
    bus.in_valid = 1'b1;
    #1;
    chk("two_held_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_flush_valid", bus.out_valid, 1'b0);
    expq.delete();
    sat_model = 0;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("no_stale_beat", bus.out_valid, 1'b0);

    bus.in_valid  = 1'b1;
    bus.in_data   = pk(8388607, 8388607, 8388607, 8388607);
    bus.cfg_mode  = 2'd0;
    bus.cfg_shift = '0;
    repeat (70000) step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("sat_sticky_max", bus.sat_count, CMAX);
    chk("sat_model_max", bus.sat_count, 32'(sat_model));

    bus.clr_stats = 1'b1;
    step();
    bus.clr_stats = 1'b0;
    chk("clr_idle", bus.sat_count, 0);
    beat(2'd0, 5'd0, 8'd0, pk(8388607, 0, 0, 0));
    bus.clr_stats = 1'b1;
    step();
    bus.clr_stats = 1'b0;
    chk("clr_wins", bus.sat_count, 0);
    step();
    beat(2'd0, 5'd0, 8'd0, pk(8388607, 0, 0, 0));
    step();
    chk("inc_after_clr", bus.sat_count, 1);
    repeat (3) step();
    chk("final_drained", 64'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
